// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO burst reader.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int CNT_W_DEF      = 8;
    localparam int SKID_DEPTH     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Words that will be held downstream after this edge: buffered plus the
    // read already in flight, less the word leaving through the output port.
    function automatic logic [2:0] outstanding(
        input logic [1:0] occ,
        input logic       inflight,
        input logic       accept
    );
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, accept};
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry first-in first-out output buffer; head entry drives the stream.
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_push;

    // A pop needs a word; a push is refused only when full and nothing leaves.
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'(SKID_DEPTH)) || w_pop);

    // Head/tail shuffle and occupancy update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: the new word replaces the one leaving.
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/fifo_reader.sv
// Burst reader: pulls burst_len words from a FIFO read port and streams them
// out through a valid/ready interface with a two-entry output buffer.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  empty,
    input  logic                  underflow,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready
);

    state_t           r_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_accepted;
    logic             r_inflight;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic                  w_buf_valid;
    logic [FIFO_WIDTH-1:0] w_buf_data;
    logic [1:0]            w_buf_count;
    logic                  w_accept;
    logic                  w_start_ok;
    logic                  w_rd_en;
    logic                  w_last_issue;
    logic                  w_last_accept;

    assign w_accept   = w_buf_valid && m_ready && !rst;
    assign w_start_ok = start && (r_state == IDLE);

    // Reads are throttled on occupancy net of this cycle's accept, so a
    // steadily draining stream keeps one read in flight every cycle while a
    // stalled stream never holds more than two words.
    assign w_rd_en = !rst && (r_state == BURST) && !empty && (r_issued < r_len)
                     && (outstanding(w_buf_count, r_inflight, w_accept) < 3'd2);

    assign w_last_issue  = w_rd_en && ((r_issued + CNT_W'(1)) == r_len);
    assign w_last_accept = w_accept && ((r_accepted + CNT_W'(1)) == r_len);

    fifo_reader_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (data_out),
        .i_pop   (w_accept),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_data),
        .o_count (w_buf_count)
    );

    // Burst FSM with its counters and registered busy/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_done     <= 1'b0;
            if (w_rd_en) begin
                r_issued <= r_issued + CNT_W'(1);
            end
            if (w_accept) begin
                r_accepted <= r_accepted + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        if (burst_len != '0) begin
                            r_state    <= BURST;
                            r_len      <= burst_len;
                            r_issued   <= '0;
                            r_accepted <= '0;
                            r_busy     <= 1'b1;
                        end else begin
                            // Empty burst: acknowledge immediately, stay idle.
                            r_done <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (w_last_issue) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_last_accept) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error: underflow sets it (and wins), an accepted start clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (underflow) begin
            r_err <= 1'b1;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end
    end

    // Outputs read as idle for the whole cycle in which reset is held.
    assign busy    = r_busy && !rst;
    assign done    = r_done && !rst;
    assign err     = r_err && !rst;
    assign rd_en   = w_rd_en;
    assign m_valid = w_buf_valid && !rst;
    assign m_data  = rst ? '0 : w_buf_data;

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: FIFO source model, word scoreboard and
// a phase-level model of busy/done/err, driven by directed and random bursts.
module tb_fifo_reader;

    localparam int W  = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          err;
    logic          rd_en;
    logic [W-1:0]  data_out;
    logic          empty;
    logic          underflow;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready;

    always #5 clk = ~clk;

    fifo_reader #(
        .FIFO_WIDTH (W),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .empty     (empty),
        .underflow (underflow),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state
    typedef enum {M_IDLE, M_ACTIVE, M_DONE} mphase_t;
    logic [W-1:0] src_q[$];      // words sitting in the source FIFO
    logic [W-1:0] exp_q[$];      // words read but not yet accepted, oldest first
    int           occ_m;         // words captured and waiting downstream
    bit           infl_m;        // a read issued last cycle
    mphase_t      ph;
    int           len_m, reads_m, acc_m;
    bit           err_m, done_m;
    bit           force_empty;
    logic [W-1:0] dout_next;
    int           cyc;
    int           acc_cyc[$];
    logic [W-1:0] acc_val[$];
    int           done_seen;
    int           first_rd_cyc;
    int           start_cyc;

    task automatic model_reset();
        ph      = M_IDLE;
        occ_m   = 0;
        infl_m  = 0;
        exp_q.delete();
        err_m   = 0;
        done_m  = 0;
        len_m   = 0;
        reads_m = 0;
        acc_m   = 0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick();
        bit exp_valid;
        bit acc;
        bit legal;
        logic [W-1:0] w;
        data_out = dout_next;
        empty    = force_empty || (src_q.size() == 0);
        #1;
        exp_valid = (occ_m != 0) && !rst;
        check_eq("busy", busy, (ph == M_ACTIVE) && !rst);
        check_eq("done", done, done_m && !rst);
        check_eq("err", err, err_m && !rst);
        check_eq("m_valid", m_valid, exp_valid);
        if (rst) check_eq("m_data_rst", m_data, 0);
        else if (exp_valid) check_eq("m_data", m_data, exp_q[0]);
        if (rd_en) begin
            legal = (ph == M_ACTIVE) && !empty && (reads_m < len_m) && !rst;
            check_eq("rd_legal", legal, 1);
        end
        if (done) done_seen++;
        acc = exp_valid && m_ready;
        if (rst) begin
            model_reset();
            dout_next = W'($urandom);
        end else begin
            if (acc) begin
                acc_cyc.push_back(cyc);
                acc_val.push_back(exp_q[0]);
                void'(exp_q.pop_front());
                acc_m++;
            end
            occ_m  = occ_m + int'(infl_m) - int'(acc);
            infl_m = rd_en;
            check_eq("outstanding", (occ_m + int'(infl_m)) <= 2, 1);
            if (rd_en && src_q.size() > 0) begin
                w = src_q.pop_front();
                exp_q.push_back(w);
                reads_m++;
                dout_next = w;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end else begin
                dout_next = W'($urandom);
            end
            if (underflow) err_m = 1;
            else if (start && ph == M_IDLE) err_m = 0;
            done_m = 0;
            case (ph)
                M_IDLE: if (start) begin
                    if (burst_len != 0) begin
                        ph      = M_ACTIVE;
                        len_m   = int'(burst_len);
                        reads_m = 0;
                        acc_m   = 0;
                    end else begin
                        done_m = 1;
                    end
                end
                M_ACTIVE: if (acc && acc_m == len_m) begin
                    ph     = M_DONE;
                    done_m = 1;
                    check_eq("nreads", reads_m, len_m);
                end
                default: ph = M_IDLE;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Mode: 0 ready high, 1 stall 5 cycles on first valid, 2 empty 3 cycles
    // after first read, 3 one underflow pulse, 4 random everything.
    task automatic run_burst(input int len, input int mode);
        int budget = 4000;
        int stall_n = 0;
        int empty_n = 0;
        bit uf_done = 0;
        acc_cyc.delete();
        acc_val.delete();
        done_seen    = 0;
        first_rd_cyc = -1;
        start        = 1;
        burst_len    = CW'(len);
        m_ready      = (mode != 1);
        force_empty  = 0;
        underflow    = 0;
        start_cyc    = cyc;
        tick();
        start = 0;
        while (ph != M_IDLE && budget > 0) begin
            m_ready = 1; force_empty = 0; underflow = 0; start = 0;
            case (mode)
                1: if (stall_n < 5 && (occ_m != 0 || stall_n > 0)) begin
                       m_ready = 0;
                       stall_n++;
                   end
                2: if (reads_m >= 1 && empty_n < 3) begin
                       force_empty = 1;
                       empty_n++;
                   end
                3: if (reads_m == 1 && !uf_done) begin
                       underflow = 1;
                       uf_done   = 1;
                   end
                4: begin
                       m_ready     = ($urandom_range(0, 3) != 0);
                       force_empty = ($urandom_range(0, 5) == 0);
                       underflow   = ($urandom_range(0, 40) == 0);
                       if ($urandom_range(0, 1) == 1) src_q.push_back(W'($urandom));
                       start       = ($urandom_range(0, 12) == 0);
                       burst_len   = CW'($urandom);
                   end
                default: begin
                end
            endcase
            tick();
            budget--;
        end
        start = 0; underflow = 0; force_empty = 0; m_ready = 1;
        check_eq("burst_timeout", budget > 0, 1);
        tick();
        tick();
    endtask

    task automatic preload(input int n, input int base);
        for (int i = 0; i < n; i++) src_q.push_back(W'(base + i));
    endtask

    initial begin
        rst = 1; start = 0; burst_len = '0; m_ready = 0; underflow = 0;
        force_empty = 0; dout_next = '0; data_out = '0; empty = 1;
        cyc = 0; first_rd_cyc = -1; done_seen = 0;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst = 0;
        tick();

        // Four preloaded words at full rate
        preload(4, 1);
        run_burst(4, 0);
        check_eq("t1_count", acc_val.size(), 4);
        for (int i = 0; i < acc_val.size(); i++) check_eq("t1_data", acc_val[i], i + 1);
        for (int i = 1; i < acc_cyc.size(); i++) check_eq("t1_consec", acc_cyc[i] - acc_cyc[i-1], 1);
        if (acc_cyc.size() > 0) check_eq("t1_latency", acc_cyc[0] - start_cyc, 3);
        check_eq("t1_done_cnt", done_seen, 1);

        // Downstream stall with three words
        preload(3, 'h10);
        run_burst(3, 1);
        check_eq("t2_count", acc_val.size(), 3);
        for (int i = 0; i < acc_val.size(); i++) check_eq("t2_data", acc_val[i], 'h10 + i);
        check_eq("t2_done_cnt", done_seen, 1);

        // Source empty for three cycles mid-burst
        preload(3, 'h20);
        run_burst(3, 2);
        check_eq("t3_count", acc_val.size(), 3);
        for (int i = 0; i < acc_val.size(); i++) check_eq("t3_data", acc_val[i], 'h20 + i);
        check_eq("t3_done_cnt", done_seen, 1);

        // Underflow pulse: err sticky through completion, cleared by next start
        preload(4, 'h30);
        run_burst(4, 3);
        check_eq("t4_err_held", err, 1);
        check_eq("t4_count", acc_val.size(), 4);
        preload(2, 'h40);
        run_burst(2, 0);
        check_eq("t5_err_cleared", err, 0);

        // Reset while two words sit in the output buffer
        preload(4, 'h50);
        start = 1; burst_len = CW'(4); m_ready = 0;
        tick();
        start = 0;
        for (int i = 0; i < 20 && occ_m != 2; i++) tick();
        check_eq("t6_buffered", occ_m, 2);
        rst = 1;
        tick();
        rst = 0;
        tick();
        check_eq("t6_valid", m_valid, 0);
        check_eq("t6_busy", busy, 0);
        src_q.delete();
        preload(1, 'h60);
        run_burst(1, 0);
        check_eq("t6_count", acc_val.size(), 1);
        if (acc_val.size() > 0) check_eq("t6_data", acc_val[0], 'h60);
        check_eq("t6_done_cnt", done_seen, 1);

        // Zero-length burst
        run_burst(0, 0);
        check_eq("t7_no_read", first_rd_cyc, -1);
        check_eq("t7_done_cnt", done_seen, 1);

        // Longest burst the counters allow
        preload(255, 'h100);
        run_burst(255, 0);
        check_eq("t8_count", acc_val.size(), 255);
        check_eq("t8_done_cnt", done_seen, 1);
        begin
            int gaps = 0;
            for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 1) gaps++;
            check_eq("t8_gaps", gaps, 0);
        end

        // Random bursts
        for (int b = 0; b < 40; b++) begin
            int len;
            len = (b == 7) ? 0 : $urandom_range(1, 12);
            run_burst(len, 4);
            check_eq("rand_count", acc_val.size(), len);
            check_eq("rand_done_cnt", done_seen, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
